// File: rtl/shift_ctrl.sv
// shift_ctrl: issue/capture/write-back sequencer driving an external 8-bit shifter.
// Optional macro SHIFT_ZERO_SKIP_EN: count-0 operations bypass the shifter and write back directly.

`ifndef SHL_FN
`define SHL_FN 2'd0
`endif
`ifndef SHR_FN
`define SHR_FN 2'd1
`endif
`ifndef ROL_FN
`define ROL_FN 2'd2
`endif
`ifndef ROR_FN
`define ROR_FN 2'd3
`endif

module shift_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_opcode,
  input  logic [2:0] in_count,
  input  logic [7:0] in_data,
  input  logic [2:0] in_rd,
  output logic [7:0] sh_data,
  output logic [1:0] sh_opcode,
  output logic [2:0] sh_count,
  output logic       sh_enable,
  input  logic [7:0] sh_out,
  input  logic       sh_c,
  output logic       wb_en,
  output logic [2:0] wb_addr,
  output logic [7:0] wb_data,
  output logic       flag_c,
  output logic       flag_z,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WRITE} state_t;

  state_t     state, next_state;
  logic [2:0] rd_q;
  logic       accept;
  logic       skip;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

`ifdef SHIFT_ZERO_SKIP_EN
  assign skip = accept && (in_count == 3'd0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = skip ? WRITE : ISSUE;
      ISSUE:   next_state = CAPTURE;
      CAPTURE: next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are registered from next_state so each is high for exactly the cycle spent in its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data   <= 8'h00;
      sh_opcode <= 2'd0;
      sh_count  <= 3'd0;
      sh_enable <= 1'b0;
      rd_q      <= 3'd0;
      wb_en     <= 1'b0;
      wb_addr   <= 3'd0;
      wb_data   <= 8'h00;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      sh_enable <= (next_state == ISSUE);
      wb_en     <= (next_state == WRITE);
      if (accept) begin
        sh_data   <= in_data;
        sh_opcode <= in_opcode;
        sh_count  <= in_count;
        rd_q      <= in_rd;
      end
      if (skip) begin
        wb_data <= in_data;
        wb_addr <= in_rd;
        flag_c  <= 1'b0;
        flag_z  <= (in_data == 8'h00);
      end
      if (state == CAPTURE) begin
        wb_data <= sh_out;
        wb_addr <= rd_q;
        flag_c  <= sh_c;
        flag_z  <= (sh_out == 8'h00);
      end
    end
  end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 SHALL have parameter none; opcode values SHALL be the shared SHL_FN, SHR_FN, ROL_FN and ROR_FN codes from defines.sv.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid / in_ready  input / output  1 / 1  issue handshake; a transfer occurs on an edge where both are high.
REQ-005 in_opcode / in_count / in_data / in_rd  input  2 / 3 / 8 / 3  shift function, shift amount, operand and destination register.
REQ-006 sh_data / sh_opcode / sh_count  output  8 / 2 / 3  operands to the shifter; registered.
REQ-007 sh_enable  output  1  shifter trigger; registered, one-cycle pulse.
REQ-008 sh_out / sh_c  input  8 / 1  shifter result and carry.
REQ-009 wb_en / wb_addr / wb_data  output  1 / 3 / 8  register-file write-back.
REQ-010 flag_c / flag_z  output  1 / 1  registered carry and zero flags.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, ISSUE, CAPTURE and WRITE.
REQ-013 in_ready SHALL be high only in IDLE, and in_valid SHALL be ignored in all other states.
REQ-014 On a transfer, the block SHALL latch opcode, count, data and rd into sh_* and an internal rd register, then enter ISSUE.
REQ-015 ISSUE: sh_enable SHALL be high for exactly this one cycle, with sh_* stable; the next state is CAPTURE.
REQ-016 CAPTURE: sh_enable SHALL be low and sh_* SHALL be held.
  - At the closing edge, sh_out SHALL be latched into wb_data and sh_c into flag_c.
  - flag_z SHALL be loaded with (sh_out == 8'h00).
  - The next state is WRITE.
REQ-017 WRITE: wb_en SHALL be high for exactly one cycle with wb_addr equal to the latched rd; the next state is IDLE.
REQ-018 Latency SHALL be 3 cycles: wb_en is high in the third cycle after the accepting edge.
  - Throughput SHALL be one operation per 4 cycles.
REQ-019 flag_c and flag_z SHALL change only at the CAPTURE closing edge (or reset) and SHALL otherwise hold.
  - They SHALL be visible in the same cycle as wb_en.
REQ-020 For ROL_FN and ROR_FN, flag_c SHALL equal sh_c (0 from the shifter).
  - No carry SHALL be synthesised internally.
REQ-021 wb_data and wb_addr SHALL hold their last values outside WRITE.
REQ-022 If in_valid is held high continuously, a new operation SHALL be accepted on the first IDLE edge after each WRITE.

Reset
REQ-023 Asserting rst_n low SHALL immediately force:
  - state IDLE;
  - sh_enable, wb_en, flag_c, flag_z, busy = 0;
  - sh_data, sh_opcode, sh_count, wb_data, wb_addr = 0;
  - in_ready = 1 as long as rst_n stays low.
REQ-024 Reset in any state, including mid-ISSUE while sh_enable is high, SHALL abort the operation with no wb_en pulse and no flag update.
REQ-025 After rst_n deasserts, the first transfer SHALL be possible at the first rising edge of clk.

Configuration
REQ-026 With macro SHIFT_ZERO_SKIP_EN defined, an accepted operation with in_count == 0 SHALL bypass the shifter:
  - no sh_enable pulse;
  - go directly from IDLE to WRITE;
  - wb_data = in_data, flag_c = 0, flag_z = (in_data == 0), loaded at the accepting edge;
  - latency 1 cycle.
REQ-027 Without SHIFT_ZERO_SKIP_EN, count-0 operations SHALL follow the normal ISSUE/CAPTURE/WRITE path with 3-cycle latency.

Verification
REQ-028 SHL_FN, data 0x81, count 1, rd 5 -> wb_en 3 cycles after accept, wb_addr 5, wb_data 0x02, flag_c 1, flag_z 0, exactly one sh_enable pulse.
REQ-029 SHR_FN, data 0x01, count 1 -> wb_data 0x00, flag_c 1, flag_z 1.
REQ-030 ROL_FN, data 0x81, count 3, then ROR_FN, data 0x81, count 1 -> wb_data 0x0C then 0xC0, with flag_c 0 both times.
REQ-031 rst_n pulsed low during CAPTURE of SHL 0x80 count 1 -> no wb_en, flags 0, in_ready 1, busy 0 immediately.
REQ-032 in_valid held high for 12 cycles -> exactly 3 accepts, each 4 cycles apart, and in_ready low in ISSUE, CAPTURE and WRITE.
REQ-033 SHL_FN, data 0x00, count 0, run with and without SHIFT_ZERO_SKIP_EN:
  - defined -> wb_en 1 cycle after accept, no sh_enable, flag_z 1;
  - undefined -> wb_en 3 cycles after accept, wb_data 0x00, flag_z 1.
